// File: rtl/turn_input_queue.sv
// rtl/turn_input_queue.sv - per-player turn-key edge detect and pending-turn queue
//
// Purpose: turns raw left/right key levels for three players into one queued
// turn code per player per game tick, plus a start pulse from the enter key.
// Config:  define TURN_QUEUE_DEPTH2_EN for a 2-entry queue per player with a
//          sticky overflow flag; otherwise each queue holds one entry and a
//          newer press replaces the pending one (overflow reads 000).
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   game_tick   in   one-cycle game step pulse; pops one entry per player
//   enable      in   round running; low flushes queues and clears turn
//   key_left    in   [2:0] left-key level per player
//   key_right   in   [2:0] right-key level per player
//   key_enter   in   enter-key level
//   turn        out  [5:0] {p2,p1,p0}: 10 left, 01 right, 00 none
//   start_pulse out  one-cycle pulse after an enter rising edge
//   overflow    out  [2:0] sticky per-player dropped-press flag
module turn_input_queue (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       game_tick,
  input  logic       enable,
  input  logic [2:0] key_left,
  input  logic [2:0] key_right,
  input  logic       key_enter,
  output logic [5:0] turn,
  output logic       start_pulse,
  output logic [2:0] overflow
);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_RIGHT = 2'b01;
  localparam logic [1:0] CODE_LEFT  = 2'b10;

  logic [2:0]      prev_l_q, prev_r_q;
  logic            prev_e_q;
  logic [5:0]      turn_q, turn_d;
  logic            start_pulse_q;

  logic [2:0]      press_l, press_r, push;
  logic [2:0][1:0] push_code;
  logic            pop;

  always_comb begin
    press_l = key_left & ~prev_l_q;
    press_r = key_right & ~prev_r_q;
    // Simultaneous left+right for one player cancel out.
    push    = (press_l ^ press_r) & {3{enable}};
    pop     = game_tick & enable;
    for (int p = 0; p < 3; p++) begin
      push_code[p] = press_l[p] ? CODE_LEFT : CODE_RIGHT;
    end
  end

`ifdef TURN_QUEUE_DEPTH2_EN
  logic [2:0][1:0] head_q, head_d, tail_q, tail_d;
  logic [2:0][1:0] cnt_q, cnt_d;
  logic [2:0]      ovf_q, ovf_d;

  // Pop is applied first, then push lands in the slot the pop left, so a
  // full queue that pops and pushes in one cycle never overflows and a
  // same-tick press cannot reach turn until the following tick.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    turn_d = turn_q;
    for (int p = 0; p < 3; p++) begin
      if (!enable) begin
        cnt_d[p]         = 2'd0;
        turn_d[2*p +: 2] = CODE_NONE;
      end else begin
        if (pop) begin
          turn_d[2*p +: 2] = (cnt_q[p] != 2'd0) ? head_q[p] : CODE_NONE;
          if (cnt_q[p] != 2'd0) begin
            head_d[p] = tail_q[p];
            cnt_d[p]  = cnt_q[p] - 2'd1;
          end
        end
        if (push[p]) begin
          case (cnt_d[p])
            2'd0: begin
              head_d[p] = push_code[p];
              cnt_d[p]  = 2'd1;
            end
            2'd1: begin
              tail_d[p] = push_code[p];
              cnt_d[p]  = 2'd2;
            end
            // Saturated: drop the press and flag it until reset.
            default: ovf_d[p] = 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  logic [2:0][1:0] head_q, head_d;
  logic [2:0]      full_q, full_d;

  // Single slot: pop empties it, then any press overwrites it (latest wins).
  always_comb begin
    head_d = head_q;
    full_d = full_q;
    turn_d = turn_q;
    for (int p = 0; p < 3; p++) begin
      if (!enable) begin
        full_d[p]        = 1'b0;
        turn_d[2*p +: 2] = CODE_NONE;
      end else begin
        if (pop) begin
          turn_d[2*p +: 2] = full_q[p] ? head_q[p] : CODE_NONE;
          full_d[p]        = 1'b0;
        end
        if (push[p]) begin
          head_d[p] = push_code[p];
          full_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      head_q <= '0;
      full_q <= '0;
    end else begin
      head_q <= head_d;
      full_q <= full_d;
    end
  end

  assign overflow = 3'b000;
`endif

  // Edge-detect registers load live levels during reset so keys held
  // across reset release produce no press.
  always_ff @(posedge CLOCK_50) begin
    prev_l_q <= key_left;
    prev_r_q <= key_right;
    prev_e_q <= key_enter;
    if (reset) begin
      turn_q        <= '0;
      start_pulse_q <= 1'b0;
    end else begin
      turn_q        <= turn_d;
      start_pulse_q <= key_enter & ~prev_e_q;
    end
  end

  assign turn        = turn_q;
  assign start_pulse = start_pulse_q;

endmodule
